// File: rtl/shift_seq_pkg.sv
// Shared types for the shift/load sequencer: FSM state, mode word, FIFO entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_seq_pkg;

  localparam int NBITS_DEFAULT = 8;

  typedef logic [1:0] mode_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  // One buffered byte together with the mode that travels with it (10 bits).
  typedef struct packed {
    mode_t       mode;
    logic [7:0]  data;
  } fifo_ent_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous FIFO of byte+mode entries; head is visible combinationally.
// Latency: a push is visible at head/level the cycle after the edge it is taken on.
// Backpressure: none internally; the caller must not push when full or pop when empty.
//
// Ports: core_clk/arst_n clock and async active-low reset; clear empties the FIFO
// synchronously; push_vld/push_dat write an entry; pop_vld retires head_dat;
// level is the number of entries held (0..DEPTH).
module sync_byte_fifo
  import shift_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       core_clk,
  input  logic                       arst_n,
  input  logic                       clear,
  input  logic                       push_vld,
  input  fifo_ent_t                  push_dat,
  input  logic                       pop_vld,
  output fifo_ent_t                  head_dat,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);

  fifo_ent_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their natural overflow.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_vld, pop_vld})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge core_clk) begin
    if (push_vld && !clear) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/shift_load_sequencer.sv
// Buffers byte+mode words and walks the register stage through load, NBITS shifts, done.
// Latency: push at E0, pop at E1, sr_load high in the cycle after E2; 10-cycle frames back-to-back.
// Backpressure: in_ready drops while the FIFO is full or flush is asserted.
//
// Ports: CK/RN clock and async active-low reset; in_valid/in_ready/in_data/in_mode
// byte intake; flush aborts the frame and empties the FIFO; sr_en/sr_load/sr_data/
// sr_mode drive the register stage; busy, frame_done, aborted, shift_cnt and
// fifo_level report status to the surrounding control logic.
module shift_load_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NBITS = NBITS_DEFAULT
) (
  input  logic                       CK,
  input  logic                       RN,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  input  mode_t                      in_mode,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       sr_en,
  output logic                       sr_load,
  output logic [7:0]                 sr_data,
  output mode_t                      sr_mode,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       aborted,
  output logic [$clog2(NBITS)-1:0]   shift_cnt,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int CW = $clog2(NBITS);
  localparam int LW = $clog2(DEPTH+1);

  state_t        state;
  logic [CW-1:0] cnt;
  fifo_ent_t     head;
  fifo_ent_t     push_ent;
  logic          push;
  logic          pop;

  assign in_ready = (fifo_level < LW'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;
  // A new byte is taken only between frames; flush blocks the pop.
  assign pop      = !flush && (fifo_level != '0) && ((state == IDLE) || (state == DONE));
  assign push_ent = '{mode: in_mode, data: in_data};

  sync_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .core_clk (CK),
    .arst_n   (RN),
    .clear    (flush),
    .push_vld (push),
    .push_dat (push_ent),
    .pop_vld  (pop),
    .head_dat (head),
    .level    (fifo_level)
  );

  // Status and strobe outputs are a registered decode of the state being left,
  // so they trail the internal state by one cycle. sr_data/sr_mode are captured
  // on the pop, one cycle ahead of sr_load, so the byte is stable when loaded.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state      <= IDLE;
      cnt        <= '0;
      sr_en      <= 1'b0;
      sr_load    <= 1'b0;
      sr_data    <= 8'h00;
      sr_mode    <= 2'b00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      aborted    <= 1'b0;
      shift_cnt  <= '0;
    end else if (flush) begin
      state      <= IDLE;
      cnt        <= '0;
      sr_en      <= 1'b0;
      sr_load    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shift_cnt  <= '0;
      // Only a frame that is still loading or shifting counts as killed.
      aborted    <= (state == LOAD) || (state == SHIFT);
    end else begin
      aborted    <= 1'b0;
      sr_en      <= (state == LOAD) || (state == SHIFT);
      sr_load    <= (state == LOAD);
      busy       <= (state != IDLE);
      frame_done <= (state == DONE);
      shift_cnt  <= (state == SHIFT) ? cnt : '0;

      if (pop) begin
        sr_data <= head.data;
        sr_mode <= head.mode;
      end

      case (state)
        IDLE: begin
          if (pop) state <= LOAD;
        end
        LOAD: begin
          state <= SHIFT;
          cnt   <= '0;
        end
        SHIFT: begin
          if (cnt == CW'(NBITS - 1)) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= pop ? LOAD : IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_load_sequencer.sv
`timescale 1ns/1ps
module tb_shift_load_sequencer;

  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [1:0] in_mode = 2'b00;
  logic       flush = 1'b0;
  logic       in_ready;
  logic       sr_en;
  logic       sr_load;
  logic [7:0] sr_data;
  logic [1:0] sr_mode;
  logic       busy;
  logic       frame_done;
  logic       aborted;
  logic [2:0] shift_cnt;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  shift_load_sequencer #(
    .DEPTH (4),
    .NBITS (8)
  ) dut (
    .CK         (CK),
    .RN         (RN),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .in_ready   (in_ready),
    .flush      (flush),
    .sr_en      (sr_en),
    .sr_load    (sr_load),
    .sr_data    (sr_data),
    .sr_mode    (sr_mode),
    .busy       (busy),
    .frame_done (frame_done),
    .aborted    (aborted),
    .shift_cnt  (shift_cnt),
    .fifo_level (fifo_level)
  );

  always #5 CK = ~CK;

  // Advance past the next rising edge; outputs are read 1 ns after it.
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sr_en"},      32'(sr_en),      0);
    check({tag, "_sr_load"},    32'(sr_load),    0);
    check({tag, "_sr_data"},    32'(sr_data),    0);
    check({tag, "_sr_mode"},    32'(sr_mode),    0);
    check({tag, "_busy"},       32'(busy),       0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_aborted"},    32'(aborted),    0);
    check({tag, "_shift_cnt"},  32'(shift_cnt),  0);
    check({tag, "_fifo_level"}, 32'(fifo_level), 0);
    check({tag, "_in_ready"},   32'(in_ready),   1);
  endtask

  initial begin
    int         load_cyc[$];
    logic [7:0] load_dat[$];
    int         done_cyc[$];
    int         idle_gaps;
    int         idx;
    int         acc_cyc[6];
    logic [7:0] got[$];
    int         ready_viol;
    int         max_lvl;
    int         n_ld;
    int         n_dn;
    int         n_busy;
    logic [7:0] ld_dat;

    // ---------------- reset ----------------
    #12;
    check_reset_outputs("rst");
    @(posedge CK);
    #1;
    RN = 1'b1;

    // ---------------- single byte ----------------
    in_valid = 1'b1; in_data = 8'hA5; in_mode = 2'b01;
    tick();
    in_valid = 1'b0;
    check("t1_level_push", 32'(fifo_level), 1);
    tick();
    check("t1_level_pop", 32'(fifo_level), 0);
    check("t1_sr_data",   32'(sr_data), 32'h A5);
    check("t1_sr_mode",   32'(sr_mode), 1);
    check("t1_no_load_yet", 32'(sr_load), 0);
    tick();
    check("t1_sr_load", 32'(sr_load), 1);
    check("t1_load_en", 32'(sr_en), 1);
    check("t1_busy",    32'(busy), 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t1_shift_en",   32'(sr_en), 1);
      check("t1_shift_ld",   32'(sr_load), 0);
      check("t1_shift_cnt",  32'(shift_cnt), 32'(k));
      check("t1_shift_nodone", 32'(frame_done), 0);
    end
    tick();
    check("t1_frame_done", 32'(frame_done), 1);
    check("t1_done_en",    32'(sr_en), 0);
    check("t1_done_cnt",   32'(shift_cnt), 0);
    tick();
    check("t1_done_pulse", 32'(frame_done), 0);
    check("t1_busy_drop",  32'(busy), 0);

    // ---------------- back-to-back frames ----------------
    idle_gaps = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 3) begin
        in_valid = 1'b1; in_data = 8'(c + 1); in_mode = 2'(c);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (sr_load) begin
        load_cyc.push_back(c);
        load_dat.push_back(sr_data);
      end
      if (frame_done) done_cyc.push_back(c);
      if (c >= 2 && c <= 31 && !busy) idle_gaps++;
    end
    check("t2_n_loads", 32'(load_cyc.size()), 3);
    check("t2_n_dones", 32'(done_cyc.size()), 3);
    check("t2_no_idle_gap", 32'(idle_gaps), 0);
    check("t2_first_load_cyc", 32'(load_cyc.size() > 0 ? load_cyc[0] : -1), 2);
    for (int i = 0; i < load_cyc.size(); i++) begin
      check("t2_sr_data_seq", 32'(load_dat[i]), 32'(i + 1));
      if (i > 0) check("t2_frame_period", 32'(load_cyc[i] - load_cyc[i-1]), 10);
      if (i < done_cyc.size()) check("t2_load_to_done", 32'(done_cyc[i] - load_cyc[i]), 9);
    end

    // ---------------- full FIFO ----------------
    idx = 0; ready_viol = 0; max_lvl = 0;
    for (int c = 0; c < 66; c++) begin
      bit take;
      in_valid = (idx < 6);
      in_data  = 8'h10 + 8'(idx);
      in_mode  = 2'b10;
      #0;
      take = in_valid && in_ready;
      if (take) acc_cyc[idx] = c;
      tick();
      if (take) idx++;
      if (fifo_level == 3'd4 && in_ready) ready_viol++;
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (sr_load) got.push_back(sr_data);
    end
    in_valid = 1'b0;
    check("t3_all_accepted", 32'(idx), 6);
    check("t3_max_level",    32'(max_lvl), 4);
    check("t3_ready_when_full", 32'(ready_viol), 0);
    check("t3_fifth_accept_cyc", 32'(acc_cyc[4]), 4);
    check("t3_sixth_accept_cyc", 32'(acc_cyc[5]), 12);
    check("t3_n_loaded", 32'(got.size()), 6);
    for (int i = 0; i < got.size(); i++) check("t3_order", 32'(got[i]), 32'(8'h10 + 8'(i)));

    // ---------------- flush mid-shift ----------------
    for (int i = 0; i < 30 && busy; i++) tick();
    check("t4_idle_start", 32'(busy), 0);
    in_valid = 1'b1; in_data = 8'h3C; in_mode = 2'b00;
    tick();
    in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 30 && !(sr_en && shift_cnt == 3'd3); i++) tick();
    check("t4_reach_cnt3", 32'(sr_en && shift_cnt == 3'd3), 1);
    check("t4_level_before", 32'(fifo_level), 1);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    #1;
    check("t4_ready_in_flush", 32'(in_ready), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t4_sr_en",     32'(sr_en), 0);
    check("t4_aborted",   32'(aborted), 1);
    check("t4_level",     32'(fifo_level), 0);
    check("t4_no_done",   32'(frame_done), 0);
    check("t4_busy",      32'(busy), 0);
    check("t4_shift_cnt", 32'(shift_cnt), 0);
    tick();
    check("t4_abort_pulse", 32'(aborted), 0);
    n_ld = 0; n_dn = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (sr_load) n_ld++;
      if (frame_done) n_dn++;
    end
    check("t4_quiet_loads", 32'(n_ld), 0);
    check("t4_quiet_dones", 32'(n_dn), 0);
    in_valid = 1'b1; in_data = 8'h5A; in_mode = 2'b11;
    tick();
    in_valid = 1'b0;
    n_ld = 0; n_dn = 0; ld_dat = 8'h00;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (sr_load) begin n_ld++; ld_dat = sr_data; end
      if (frame_done) n_dn++;
    end
    check("t4_after_loads", 32'(n_ld), 1);
    check("t4_after_data",  32'(ld_dat), 32'h5A);
    check("t4_after_dones", 32'(n_dn), 1);

    // ---------------- push in DONE with one entry held ----------------
    in_valid = 1'b1; in_data = 8'hC1; in_mode = 2'b00;
    tick();
    in_data = 8'hC2;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 30 && !(sr_en && shift_cnt == 3'd7); i++) tick();
    check("t5_reach_last_shift", 32'(sr_en && shift_cnt == 3'd7), 1);
    check("t5_level_before", 32'(fifo_level), 1);
    in_valid = 1'b1; in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    check("t5_level_same", 32'(fifo_level), 1);
    check("t5_frame_done", 32'(frame_done), 1);
    tick();
    check("t5_b2b_load", 32'(sr_load), 1);
    check("t5_b2b_data", 32'(sr_data), 32'hC2);

    // ---------------- reset mid-shift ----------------
    tick();
    tick();
    check("t5_mid_shift", 32'(sr_en && !sr_load), 1);
    RN = 1'b0;
    #1;
    check_reset_outputs("t5_rn");
    #2;
    RN = 1'b1;
    n_busy = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy || sr_load) n_busy++;
    end
    check("t5_fifo_lost", 32'(n_busy), 0);

    // ---------------- flush while idle ----------------
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_idle_flush_no_abort", 32'(aborted), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
